// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART receive path.
// Holds the receiver state encoding and the baud divisor calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_e;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_buffered_fifo.sv
// Small synchronous FIFO with wrap-bit pointers and a combinational head.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_ptr == rd_ptr);
    assign full_o  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                     (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata_i;
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with mid-bit sampling, break handling and a
// small receive FIFO popped through a valid/ready interface.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUDRATE   = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       ser_rx,
    output logic [7:0] rdata_o,
    output logic       rvalid_o,
    input  logic       rready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int DIV = calc_div(CLK_FREQ, BAUDRATE);
    localparam int CW  = $clog2(DIV + 1);

    uart_rx_state_e state;
    logic [1:0]     sync_q;
    logic           rx_s;
    logic [CW-1:0]  cnt;
    logic [2:0]     idx;
    logic [7:0]     shreg;
    logic           tick;
    logic           push;
    logic           full;
    logic           empty;

    assign rx_s = sync_q[1];
    assign tick = (cnt == '0);
    assign push = (state == STOP) && tick && rx_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], ser_rx};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
            if (!tick) cnt <= cnt - 1'b1;
            unique case (state)
                IDLE: if (!rx_s) begin
                    state <= START;
                    cnt   <= CW'(DIV/2 - 1);
                end
                START: if (tick) begin
                    if (rx_s) begin
                        state <= IDLE;
                    end else begin
                        state <= DATA;
                        cnt   <= CW'(DIV - 1);
                        idx   <= '0;
                    end
                end
                DATA: if (tick) begin
                    shreg[idx] <= rx_s;
                    cnt        <= CW'(DIV - 1);
                    idx        <= idx + 1'b1;
                    if (idx == 3'd7) state <= STOP;
                end
                STOP: if (tick) begin
                    // full is only an overrun if no pop frees a slot this cycle
                    overrun_o   <= rx_s && full && !rready_i;
                    frame_err_o <= !rx_s;
                    state       <= rx_s ? IDLE : BREAK;
                end
                BREAK: if (rx_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (push),
        .wdata_i(shreg),
        .pop_i  (rready_i),
        .full_o (full),
        .empty_o(empty),
        .head_o (rdata_o)
    );

    assign rvalid_o = !empty;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Bench for uart_rx_buffered: frame-level byte queue model plus
// directed and random serial traffic.
`timescale 1ns/1ps
module tb_uart_rx_buffered;

    localparam int  DEPTH = 4;
    localparam time BIT   = 8680;

    logic       clk_i = 0;
    logic       rst_ni = 0;
    logic       ser_rx = 1;
    logic [7:0] rdata_o;
    logic       rvalid_o;
    logic       rready_i = 0;
    logic       frame_err_o;
    logic       overrun_o;

    int checks = 0;
    int errors = 0;
    int ferr_cnt = 0;
    int ovr_cnt = 0;
    int exp_ferr = 0;
    int exp_ovr = 0;
    int pops = 0;
    bit rand_rdy = 0;
    logic [7:0] mq[$];
    logic [7:0] plog[$];

    uart_rx_buffered #(
        .CLK_FREQ(25_000_000),
        .BAUDRATE(115200),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .ser_rx(ser_rx),
        .rdata_o(rdata_o),
        .rvalid_o(rvalid_o),
        .rready_i(rready_i),
        .frame_err_o(frame_err_o),
        .overrun_o(overrun_o)
    );

    always #20 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model is updated when the stop bit starts, so it can only lead the DUT.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (frame_err_o) ferr_cnt++;
            if (overrun_o) ovr_cnt++;
            checks++;
            if (rvalid_o && mq.size() == 0) begin
                errors++;
                $display("FAIL rvalid_empty: got 1 expected 0");
            end else if (rvalid_o) begin
                checks++;
                if (rdata_o !== mq[0]) begin
                    errors++;
                    $display("FAIL rdata: got %0h expected %0h",
                             rdata_o, mq[0]);
                end
                if (rready_i) begin
                    plog.push_back(rdata_o);
                    void'(mq.pop_front());
                    pops++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (rand_rdy) rready_i = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [7:0] b, input logic stop);
        ser_rx = 0;
        #BIT;
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            #BIT;
        end
        if (!stop) exp_ferr++;
        else if (mq.size() < DEPTH) mq.push_back(b);
        else exp_ovr++;
        ser_rx = stop;
        #BIT;
        ser_rx = 1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(posedge clk_i);
        #1;
        rready_i = 1;
        while (mq.size() != 0 && n < 200) begin
            @(posedge clk_i);
            n++;
        end
        chk("drain_timeout", 32'(mq.size()), 0);
        repeat (3) @(posedge clk_i);
        #1;
        rready_i = 0;
        @(negedge clk_i);
        chk("rvalid_after_drain", 32'(rvalid_o), 0);
    endtask

    initial begin
        logic [7:0] b;
        int n;
        repeat (5) @(negedge clk_i);
        chk("rst_rvalid", 32'(rvalid_o), 0);
        chk("rst_rdata", 32'(rdata_o), 0);
        chk("rst_ferr", 32'(frame_err_o), 0);
        chk("rst_ovr", 32'(overrun_o), 0);
        rst_ni = 1;
        #(2*BIT);

        rready_i = 1;
        send(8'h68, 1);
        #(2*BIT);
        chk("h_pops", 32'(pops), 1);
        chk("h_byte", 32'(plog[0]), 32'h68);
        chk("h_ferr", 32'(ferr_cnt), 0);
        chk("h_ovr", 32'(ovr_cnt), 0);
        rready_i = 0;
        plog.delete();

        send(8'h55, 1);
        send(8'hAA, 1);
        send(8'h00, 1);
        send(8'hFF, 1);
        #BIT;
        @(negedge clk_i);
        chk("four_rvalid", 32'(rvalid_o), 1);
        chk("four_head", 32'(rdata_o), 32'h55);
        drain();
        chk("four_n", 32'(plog.size()), 4);
        chk("four_order", {plog[0], plog[1], plog[2], plog[3]},
            32'h55AA00FF);
        plog.delete();

        for (int i = 1; i <= 5; i++) send(8'(i), 1);
        #BIT;
        chk("ovr_pulse", 32'(ovr_cnt), 1);
        drain();
        chk("ovr_order", {plog[0], plog[1], plog[2], plog[3]},
            32'h01020304);
        chk("ovr_n", 32'(plog.size()), 4);
        plog.delete();

        send(8'h3C, 0);
        ser_rx = 0;
        #(3*BIT);
        ser_rx = 1;
        #(2*BIT);
        chk("brk_ferr", 32'(ferr_cnt), 1);
        chk("brk_empty", 32'(rvalid_o), 0);
        rready_i = 1;
        send(8'h41, 1);
        #(2*BIT);
        chk("brk_next", 32'(plog[0]), 32'h41);
        rready_i = 0;
        plog.delete();

        ser_rx = 0;
        #2000;
        ser_rx = 1;
        #(2*BIT);
        chk("glitch_rvalid", 32'(rvalid_o), 0);
        chk("glitch_ferr", 32'(ferr_cnt), 1);

        send(8'h99, 1);
        #BIT;
        ser_rx = 0;
        #BIT;
        for (int i = 0; i < 4; i++) begin
            ser_rx = i[0];
            #BIT;
        end
        ser_rx = 0;
        #(BIT/2);
        rst_ni = 0;
        mq.delete();
        #100;
        chk("mid_rvalid", 32'(rvalid_o), 0);
        chk("mid_rdata", 32'(rdata_o), 0);
        chk("mid_ferr", 32'(frame_err_o), 0);
        chk("mid_ovr", 32'(overrun_o), 0);
        ser_rx = 1;
        #100;
        rst_ni = 1;
        #(2*BIT);
        rready_i = 1;
        send(8'h7E, 1);
        #(2*BIT);
        chk("mid_next", 32'(plog[0]), 32'h7E);
        plog.delete();

        rand_rdy = 1;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (mq.size() >= DEPTH && n < 1000) begin
                @(posedge clk_i);
                n++;
            end
            b = 8'($urandom);
            send(b, 1);
        end
        #BIT;
        rand_rdy = 0;
        drain();

        chk("tot_ferr", 32'(ferr_cnt), 32'(exp_ferr));
        chk("tot_ovr", 32'(ovr_cnt), 32'(exp_ovr));
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
